// File: rtl/dmard_mem_responder_pkg.sv
// Shared types and constants for the DMA read memory responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmard_mem_responder_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_ISSUE = 2'd1,
    RSP_DRAIN = 2'd2,
    RSP_DONE  = 2'd3
  } rsp_state_e;

  // Request type selected by the arbiter
  typedef enum logic {
    GRANT_DATA  = 1'b0,
    GRANT_DESCP = 1'b1
  } grant_e;

  localparam int         DESCP_DWORDS = 4;
  localparam logic [8:0] DESCP_BEATS  = 9'(DESCP_DWORDS);

  // A data length of zero encodes the maximum transfer of 256 dwords.
  function automatic logic [8:0] data_beats(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/dmard_mem_responder_if.sv
// Request/response bundle between the DMA read engine, the responder and memory.
// Latency: n/a (wiring only).
// Backpressure: mem_ready throttles reads; the data FIFO side has none.
// Ports: descriptor fetch (req/ack/4 dwords), data fetch (req/ack/FIFO write),
//        memory read port (rden/addr/ready, rdvalid/rddata), busy, err_pulse.
interface dmard_mem_responder_if;

  logic        fetch_descp;
  logic [31:0] addr_descp;
  logic [7:0]  length_descp;
  logic        ack_fetch_descp;
  logic        descpdata_valid;
  logic [31:0] descp_dword0;
  logic [31:0] descp_dword1;
  logic [31:0] descp_dword2;
  logic [31:0] descp_dword3;

  logic        fetch_data;
  logic [31:0] addr_data;
  logic [7:0]  length_data;
  logic        ack_fetch_data;
  logic [31:0] datafifo_wrdata;
  logic        datafifo_datavalid;

  logic        mem_rden;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rdvalid;
  logic [31:0] mem_rddata;

  logic        busy;
  logic        err_pulse;

  // Environment side: requester plus memory model
  modport master (
    output fetch_descp, addr_descp, length_descp,
    output fetch_data, addr_data, length_data,
    output mem_ready, mem_rdvalid, mem_rddata,
    input  ack_fetch_descp, descpdata_valid,
    input  descp_dword0, descp_dword1, descp_dword2, descp_dword3,
    input  ack_fetch_data, datafifo_wrdata, datafifo_datavalid,
    input  mem_rden, mem_addr, busy, err_pulse
  );

  // Responder side
  modport slave (
    input  fetch_descp, addr_descp, length_descp,
    input  fetch_data, addr_data, length_data,
    input  mem_ready, mem_rdvalid, mem_rddata,
    output ack_fetch_descp, descpdata_valid,
    output descp_dword0, descp_dword1, descp_dword2, descp_dword3,
    output ack_fetch_data, datafifo_wrdata, datafifo_datavalid,
    output mem_rden, mem_addr, busy, err_pulse
  );

endinterface

// File: rtl/dmard_rr_arb2.sv
// Two-way round-robin arbiter (descriptor vs data) with a last-grant register.
// Latency: combinational grant; last-grant updates on the clock after a grant.
// Backpressure: grants only while en is high; requests are otherwise ignored.
// Ports: clk, rstb, en, req_descp, req_data -> gnt_vld, gnt_sel.
module dmard_rr_arb2
  import dmard_mem_responder_pkg::*;
(
  input  logic   clk,
  input  logic   rstb,
  input  logic   en,
  input  logic   req_descp,
  input  logic   req_data,
  output logic   gnt_vld,
  output grant_e gnt_sel
);

  grant_e last_q;

  always_comb begin
    gnt_vld = en && (req_descp || req_data);
    if (req_descp && req_data) begin
      // Contention: favour whichever type did not win last time
      gnt_sel = (last_q == GRANT_DATA) ? GRANT_DESCP : GRANT_DATA;
    end else if (req_descp) begin
      gnt_sel = GRANT_DESCP;
    end else begin
      gnt_sel = GRANT_DATA;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= GRANT_DATA;
    end else if (gnt_vld) begin
      last_q <= gnt_sel;
    end
  end

endmodule

// File: rtl/dmard_mem_responder.sv
// Memory-side responder: arbitrates descriptor/data fetches and issues dword reads.
// Latency: ack same cycle as grant; data dword 1 cycle after mem_rdvalid; descp valid in DONE.
// Backpressure: mem_ready and the outstanding limit stall issue; no backpressure to the data FIFO.
// Ports: clk, rstb (async active-low), bus (slave modport of dmard_mem_responder_if).
module dmard_mem_responder
  import dmard_mem_responder_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OSTD_W          = 3
) (
  input  logic                  clk,
  input  logic                  rstb,
  dmard_mem_responder_if.slave  bus
);

  localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MAX_OUTSTANDING);

  rsp_state_e        state_q, state_d;
  grant_e            sel_q;
  logic [29:0]       base_q;
  logic [8:0]        beats_q;
  logic [8:0]        issued_q;
  logic [8:0]        returned_q;
  logic [OSTD_W-1:0] ostd_q;
  logic [31:0]       dword_q [DESCP_DWORDS];
  logic              dv_q;
  logic [31:0]       wrdata_q;

  logic   gnt_vld;
  grant_e gnt_sel;
  logic   start;
  logic   rden;
  logic   accept;
  logic   ret_ok;
  logic   ret_err;
  logic   len_bad;
  logic   unused_addr_bits;

  dmard_rr_arb2 u_arb (
    .clk       (clk),
    .rstb      (rstb),
    .en        (state_q == RSP_IDLE),
    .req_descp (bus.fetch_descp),
    .req_data  (bus.fetch_data),
    .gnt_vld   (gnt_vld),
    .gnt_sel   (gnt_sel)
  );

  // Next-state and issue control
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    rden    = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (gnt_vld) begin
          start   = 1'b1;
          state_d = RSP_ISSUE;
        end
      end
      RSP_ISSUE: begin
        rden = (issued_q < beats_q) && (ostd_q < OSTD_MAX);
        if (rden && bus.mem_ready && (issued_q + 9'd1 == beats_q)) begin
          state_d = RSP_DRAIN;
        end
      end
      RSP_DRAIN: begin
        if ((ostd_q == '0) && (returned_q == beats_q)) begin
          state_d = RSP_DONE;
        end
      end
      RSP_DONE: begin
        state_d = RSP_IDLE;
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
  end

  assign accept  = rden && bus.mem_ready;
  // A return with nothing outstanding is stray (e.g. left over from a reset) and is dropped
  assign ret_ok  = bus.mem_rdvalid && (ostd_q != '0);
  assign ret_err = bus.mem_rdvalid && (ostd_q == '0);
  assign len_bad = (bus.length_descp != 8'(DESCP_DWORDS));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= RSP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sel_q      <= GRANT_DATA;
      base_q     <= '0;
      beats_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      ostd_q     <= '0;
      dv_q       <= 1'b0;
      wrdata_q   <= '0;
      for (int i = 0; i < DESCP_DWORDS; i++) begin
        dword_q[i] <= '0;
      end
    end else begin
      if (start) begin
        sel_q      <= gnt_sel;
        base_q     <= (gnt_sel == GRANT_DESCP) ? bus.addr_descp[31:2] : bus.addr_data[31:2];
        // Descriptors always fetch a fixed size regardless of the requested length
        beats_q    <= (gnt_sel == GRANT_DESCP) ? DESCP_BEATS : data_beats(bus.length_data);
        issued_q   <= '0;
        returned_q <= '0;
      end else begin
        if (accept) begin
          issued_q <= issued_q + 9'd1;
        end
        if (ret_ok) begin
          returned_q <= returned_q + 9'd1;
        end
      end

      // Simultaneous accept and return cancel out
      if (accept && !ret_ok) begin
        ostd_q <= ostd_q + OSTD_W'(1);
      end else if (!accept && ret_ok) begin
        ostd_q <= ostd_q - OSTD_W'(1);
      end

      dv_q <= ret_ok && (sel_q == GRANT_DATA);
      if (ret_ok && (sel_q == GRANT_DATA)) begin
        wrdata_q <= bus.mem_rddata;
      end
      // Returns are in order, so the return count selects the descriptor dword
      if (ret_ok && (sel_q == GRANT_DESCP)) begin
        dword_q[returned_q[1:0]] <= bus.mem_rddata;
      end
    end
  end

  assign bus.mem_rden           = rden;
  assign bus.mem_addr           = {base_q, 2'b00} + {21'd0, issued_q, 2'b00};
  assign bus.ack_fetch_descp    = start && (gnt_sel == GRANT_DESCP);
  assign bus.ack_fetch_data     = start && (gnt_sel == GRANT_DATA);
  assign bus.err_pulse          = ret_err || (start && (gnt_sel == GRANT_DESCP) && len_bad);
  assign bus.busy               = (state_q != RSP_IDLE);
  assign bus.descpdata_valid    = (state_q == RSP_DONE) && (sel_q == GRANT_DESCP);
  assign bus.datafifo_datavalid = dv_q;
  assign bus.datafifo_wrdata    = wrdata_q;
  assign bus.descp_dword0       = dword_q[0];
  assign bus.descp_dword1       = dword_q[1];
  assign bus.descp_dword2       = dword_q[2];
  assign bus.descp_dword3       = dword_q[3];

  // Byte-offset bits of the request addresses are ignored
  assign unused_addr_bits = ^{bus.addr_descp[1:0], bus.addr_data[1:0]};

endmodule

// File: tb/tb_dmard_mem_responder.sv
// Randomised bench for dmard_mem_responder with a behavioural memory and reference model.
// Latency: n/a (testbench).
// Backpressure: memory model randomises mem_ready and return latency.
module tb_dmard_mem_responder;

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  always #5 clk = ~clk;

  dmard_mem_responder_if bus ();

  dmard_mem_responder #(
    .MAX_OUTSTANDING (4),
    .OSTD_W          (3)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model knobs
  int ready_pct    = 100;
  int max_lat      = 2;
  bit hold_ret     = 1'b0;
  bit mem_override = 1'b0;
  bit inj_rdvalid  = 1'b0;

  // Reference model state
  int          cyc = 0;
  mreq_t       mem_q[$];
  logic [31:0] ret_addr_q[$];
  logic [31:0] acc_log[$];
  int          out_model = 0;
  int          acc_idx = 0;
  int          cur_beats = 0;
  bit          cur_descp = 1'b0;
  logic [31:0] cur_base = '0;
  bit          in_xfer = 1'b0;
  bit          pend_dv = 1'b0;
  logic [31:0] pend_data = '0;
  int          last_grant = -1;

  // Event counters
  int n_ack = 0, n_acc = 0, n_ret = 0, n_dv = 0, n_dval = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: accepts recorded by the monitor, returns in order after a random latency
  initial begin
    bus.mem_ready   = 1'b0;
    bus.mem_rdvalid = 1'b0;
    bus.mem_rddata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = ($urandom_range(99) < ready_pct);
      if (!rstb) mem_q.delete();
      if (mem_override) begin
        bus.mem_rdvalid = inj_rdvalid;
        bus.mem_rddata  = $urandom;
      end else if (rstb && !hold_ret && mem_q.size() > 0 && mem_q[0].due <= cyc
                   && $urandom_range(99) < 80) begin
        bus.mem_rdvalid = 1'b1;
        bus.mem_rddata  = mem_fn(mem_q[0].addr);
        void'(mem_q.pop_front());
      end else begin
        bus.mem_rdvalid = 1'b0;
        bus.mem_rddata  = $urandom;
      end
    end
  end

  // Monitor and reference model, sampled mid-cycle after all inputs are driven
  initial begin
    logic acc, ret, exp_err, exp_rden;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rstb) begin
        ret_addr_q.delete();
        out_model = 0;
        in_xfer   = 1'b0;
        acc_idx   = 0;
        cur_beats = 0;
        pend_dv   = 1'b0;
        continue;
      end
      // Registered outputs from the previous edge
      check_eq("datavalid", bus.datafifo_datavalid, pend_dv);
      if (pend_dv) check_eq("wrdata", bus.datafifo_wrdata, pend_data);
      if (bus.datafifo_datavalid) n_dv++;
      if (bus.descpdata_valid) begin
        n_dval++;
        check_eq("descp_dw0", bus.descp_dword0, mem_fn(cur_base));
        check_eq("descp_dw1", bus.descp_dword1, mem_fn(cur_base + 32'd4));
        check_eq("descp_dw2", bus.descp_dword2, mem_fn(cur_base + 32'd8));
        check_eq("descp_dw3", bus.descp_dword3, mem_fn(cur_base + 32'd12));
      end
      // Issue must proceed exactly while reads remain and fewer than 4 are unreturned
      exp_rden = in_xfer && (acc_idx < cur_beats) && (out_model < 4);
      check_eq("mem_rden", bus.mem_rden, exp_rden);
      acc = bus.mem_rden && bus.mem_ready;
      ret = bus.mem_rdvalid;
      exp_err = (bus.ack_fetch_descp && bus.length_descp != 8'd4) || (ret && out_model == 0);
      check_eq("err_pulse", bus.err_pulse, exp_err);
      if (bus.err_pulse) n_err++;
      pend_dv = 1'b0;
      if (acc) begin
        check_eq("mem_addr", bus.mem_addr, cur_base + 32'(acc_idx) * 32'd4);
        acc_log.push_back(bus.mem_addr);
        ret_addr_q.push_back(bus.mem_addr);
        mem_q.push_back('{addr: bus.mem_addr, due: cyc + int'($urandom_range(max_lat, 1))});
        acc_idx++;
        n_acc++;
      end
      if (ret && out_model != 0) begin
        a = ret_addr_q.pop_front();
        n_ret++;
        if (!cur_descp) begin
          pend_dv   = 1'b1;
          pend_data = mem_fn(a);
        end
      end
      out_model = out_model + (acc ? 1 : 0) - ((ret && out_model != 0) ? 1 : 0);
      if (bus.ack_fetch_descp || bus.ack_fetch_data) begin
        check_eq("ack_exclusive", bus.ack_fetch_descp && bus.ack_fetch_data, 0);
        n_ack++;
        last_grant = bus.ack_fetch_descp ? 1 : 0;
        cur_descp  = bus.ack_fetch_descp;
        cur_base   = bus.ack_fetch_descp ? {bus.addr_descp[31:2], 2'b00}
                                         : {bus.addr_data[31:2], 2'b00};
        cur_beats  = bus.ack_fetch_descp ? 4
                   : ((bus.length_data == 8'd0) ? 256 : int'(bus.length_data));
        acc_idx    = 0;
        in_xfer    = 1'b1;
        acc_log.delete();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic wait_acks(input int target, input string tag);
    int n = 0;
    while (n_ack < target && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq(tag, 32'(n_ack >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (bus.busy && n < 5000);
    check_eq({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic do_fetch(input bit descp, input logic [31:0] addr, input logic [7:0] len,
                          input string tag);
    int a0, acc0, r0, dv0, dval0, e0, beats;
    beats = descp ? 4 : ((len == 8'd0) ? 256 : int'(len));
    a0 = n_ack; acc0 = n_acc; r0 = n_ret; dv0 = n_dv; dval0 = n_dval; e0 = n_err;
    @(negedge clk);
    if (descp) begin
      bus.fetch_descp = 1'b1; bus.addr_descp = addr; bus.length_descp = len;
    end else begin
      bus.fetch_data = 1'b1; bus.addr_data = addr; bus.length_data = len;
    end
    #2;
    wait_acks(a0 + 1, {tag, "_ack"});
    // Request stays high one cycle past its ack
    @(negedge clk);
    bus.fetch_descp = 1'b0;
    bus.fetch_data  = 1'b0;
    wait_idle(tag);
    check_eq({tag, "_acks"}, n_ack - a0, 1);
    check_eq({tag, "_grant"}, last_grant, descp ? 1 : 0);
    check_eq({tag, "_accepts"}, n_acc - acc0, beats);
    check_eq({tag, "_returns"}, n_ret - r0, beats);
    check_eq({tag, "_datavalids"}, n_dv - dv0, descp ? 0 : beats);
    check_eq({tag, "_descpvalids"}, n_dval - dval0, descp ? 1 : 0);
    check_eq({tag, "_errs"}, n_err - e0, (descp && len != 8'd4) ? 1 : 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #3 rstb = 1'b0;
    repeat (3) @(negedge clk);
    #3 rstb = 1'b1;
  endtask

  initial begin
    int a0, acc0, r0, dv0, e0, n;
    bus.fetch_descp = 1'b0; bus.addr_descp = '0; bus.length_descp = '0;
    bus.fetch_data  = 1'b0; bus.addr_data  = '0; bus.length_data  = '0;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_rden", bus.mem_rden, 0);
    check_eq("rst_dv", bus.datafifo_datavalid, 0);
    check_eq("rst_wrdata", bus.datafifo_wrdata, 0);
    check_eq("rst_dval", bus.descpdata_valid, 0);
    check_eq("rst_dw0", bus.descp_dword0, 0);
    check_eq("rst_dw3", bus.descp_dword3, 0);
    check_eq("rst_err", bus.err_pulse, 0);
    #1 rstb = 1'b1;

    // Descriptor fetch, fixed latency, memory always ready
    ready_pct = 100; max_lat = 2;
    do_fetch(1'b1, 32'h0000_1000, 8'd4, "t1");
    check_eq("t1_addr0", acc_log[0], 32'h0000_1000);
    check_eq("t1_addr3", acc_log[3], 32'h0000_100C);
    check_eq("t1_dw0_held", bus.descp_dword0, mem_fn(32'h0000_1000));

    // Maximum-length data fetch from an unaligned address
    do_fetch(1'b0, 32'h0000_2002, 8'd0, "t2");
    check_eq("t2_addr0", acc_log[0], 32'h0000_2000);
    check_eq("t2_addr255", acc_log[255], 32'h0000_23FC);

    // Contention, twice, starting from reset last-grant
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      a0 = n_ack;
      @(negedge clk);
      bus.fetch_descp = 1'b1; bus.addr_descp = 32'h3000 + 32'(r) * 32'h100; bus.length_descp = 8'd4;
      bus.fetch_data  = 1'b1; bus.addr_data  = 32'h4000 + 32'(r) * 32'h100; bus.length_data  = 8'd3;
      #2;
      wait_acks(a0 + 1, "t3_ack1");
      check_eq("t3_first_descp", last_grant, 1);
      @(negedge clk);
      bus.fetch_descp = 1'b0;
      #2;
      wait_acks(a0 + 2, "t3_ack2");
      check_eq("t3_second_data", last_grant, 0);
      @(negedge clk);
      bus.fetch_data = 1'b0;
      wait_idle("t3");
      check_eq("t3_acks", n_ack - a0, 2);
    end

    // Outstanding limit while memory withholds returns
    hold_ret = 1'b1; ready_pct = 100; max_lat = 2;
    a0 = n_ack; acc0 = n_acc; r0 = n_ret; dv0 = n_dv;
    @(negedge clk);
    bus.fetch_data = 1'b1; bus.addr_data = 32'h0000_5000; bus.length_data = 8'd8;
    #2;
    wait_acks(a0 + 1, "t4_ack");
    @(negedge clk);
    bus.fetch_data = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check_eq("t4_acc_cap", n_acc - acc0, 4);
    check_eq("t4_rden_stalled", bus.mem_rden, 0);
    check_eq("t4_no_returns", n_ret - r0, 0);
    hold_ret = 1'b0;
    wait_idle("t4");
    check_eq("t4_accepts", n_acc - acc0, 8);
    check_eq("t4_datavalids", n_dv - dv0, 8);

    // Address wrap and bad descriptor length
    do_fetch(1'b0, 32'hFFFF_FFF8, 8'd4, "t5");
    check_eq("t5_a0", acc_log[0], 32'hFFFF_FFF8);
    check_eq("t5_a1", acc_log[1], 32'hFFFF_FFFC);
    check_eq("t5_a2", acc_log[2], 32'h0000_0000);
    check_eq("t5_a3", acc_log[3], 32'h0000_0004);
    do_fetch(1'b1, 32'h0000_6000, 8'd8, "t5d");

    // Randomised mix of traffic and memory behaviour
    for (int i = 0; i < 12; i++) begin
      bit d;
      logic [7:0] l;
      ready_pct = int'($urandom_range(100, 30));
      max_lat   = int'($urandom_range(6, 1));
      d = 1'($urandom_range(1));
      if (d) l = ($urandom_range(3) == 0) ? 8'd7 : 8'd4;
      else   l = 8'($urandom_range(16, 1));
      do_fetch(d, $urandom, l, "rnd");
    end

    // Reset in the middle of a data transfer
    ready_pct = 100; max_lat = 3;
    a0 = n_ack; acc0 = n_acc;
    @(negedge clk);
    bus.fetch_data = 1'b1; bus.addr_data = 32'h0000_7000; bus.length_data = 8'd8;
    #2;
    wait_acks(a0 + 1, "t6_ack");
    @(negedge clk);
    bus.fetch_data = 1'b0;
    n = 0;
    while (n_acc - acc0 < 3 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("t6_beat3", 32'(n_acc - acc0 >= 3), 1);
    hold_ret = 1'b1;
    @(negedge clk);
    #3 rstb = 1'b0;
    #1;
    check_eq("t6_rst_busy", bus.busy, 0);
    check_eq("t6_rst_rden", bus.mem_rden, 0);
    check_eq("t6_rst_dv", bus.datafifo_datavalid, 0);
    check_eq("t6_rst_ack", bus.ack_fetch_data, 0);
    check_eq("t6_rst_err", bus.err_pulse, 0);
    e0 = n_err; dv0 = n_dv;
    repeat (2) @(negedge clk);
    #3 rstb = 1'b1;
    @(negedge clk);
    #2;
    check_eq("t6_idle", bus.busy, 0);
    mem_override = 1'b1;
    inj_rdvalid  = 1'b1;
    @(negedge clk);
    #2;
    check_eq("t6_late_err", bus.err_pulse, 1);
    inj_rdvalid = 1'b0;
    @(negedge clk);
    #2;
    check_eq("t6_no_dv", bus.datafifo_datavalid, 0);
    check_eq("t6_err_count", n_err - e0, 1);
    check_eq("t6_dv_count", n_dv - dv0, 0);
    check_eq("t6_still_idle", bus.busy, 0);
    mem_override = 1'b0;
    hold_ret     = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
